// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
// Divide support is compiled in only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

  localparam int ITER_DEF = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation, shared by operand magnitude
// conversion and result sign correction (32+32 split or one 64-bit value).
module muldiv_sign_fix (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_neg_a,
  input  logic        i_neg_b,
  input  logic        i_wide,
  output logic [31:0] o_a,
  output logic [31:0] o_b
);

  logic [63:0] w_neg_wide;

  assign w_neg_wide = 64'd0 - {i_a, i_b};

  // Wide mode negates {a,b} as one value; split mode negates each half.
  always_comb begin
    o_a = i_a;
    o_b = i_b;
    if (i_wide) begin
      if (i_neg_a) begin
        o_a = w_neg_wide[63:32];
        o_b = w_neg_wide[31:0];
      end
    end else begin
      if (i_neg_a) o_a = 32'd0 - i_a;
      if (i_neg_b) o_b = 32'd0 - i_b;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / shift-subtract divider with HI/LO.
// Define MULDIV_DIV_EN to build the divide datapath (DIVU, DIV).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int ITER = ITER_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_acc_hi;
  logic [31:0]   r_acc_lo;
  logic [31:0]   r_b;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic          r_busy;
  logic          r_done;
  logic          r_is_div;
  logic          r_neg_hi;
  logic          r_neg_lo;

  logic          w_sgn;
  logic          w_is_div;
  logic          w_accept;
  logic [31:0]   w_ia;
  logic [31:0]   w_ib;
  logic          w_na;
  logic          w_nb;
  logic          w_wide;
  logic [31:0]   w_fa;
  logic [31:0]   w_fb;
  logic [32:0]   w_sum;
  logic [31:0]   w_step_hi;
  logic [31:0]   w_step_lo;
`ifdef MULDIV_DIV_EN
  logic [32:0]   w_rem_sh;
  logic          w_ge;
`endif

  assign w_sgn = (op == OP_MULT) || (op == OP_DIV);

`ifdef MULDIV_DIV_EN
  assign w_is_div = (op == OP_DIVU) || (op == OP_DIV);
  assign w_accept = start;
`else
  assign w_is_div = 1'b0;
  assign w_accept = start & ~op[1];
`endif

  // Sign-fix input select: operands while idle, accumulators afterwards.
  always_comb begin
    w_ia   = r_acc_hi;
    w_ib   = r_acc_lo;
    w_na   = r_neg_hi;
    w_nb   = r_neg_lo;
    w_wide = ~r_is_div;
    if (r_state == IDLE) begin
      w_ia   = rs_data;
      w_ib   = rt_data;
      w_na   = w_sgn & rs_data[31];
      w_nb   = w_sgn & rt_data[31];
      w_wide = 1'b0;
    end
  end

  muldiv_sign_fix u_sign_fix (
    .i_a     (w_ia),
    .i_b     (w_ib),
    .i_neg_a (w_na),
    .i_neg_b (w_nb),
    .i_wide  (w_wide),
    .o_a     (w_fa),
    .o_b     (w_fb)
  );

  // One loop iteration: shift-add multiply or restoring divide step.
  always_comb begin
    w_sum     = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : 33'd0);
    w_step_hi = w_sum[32:1];
    w_step_lo = {w_sum[0], r_acc_lo[31:1]};
`ifdef MULDIV_DIV_EN
    w_rem_sh = {r_acc_hi, r_acc_lo[31]};
    w_ge     = w_rem_sh >= {1'b0, r_b};
    if (r_is_div) begin
      w_step_hi = w_ge ? (w_rem_sh[31:0] - r_b) : w_rem_sh[31:0];
      w_step_lo = {r_acc_lo[30:0], w_ge};
    end
`endif
  end

  // Control FSM with loop registers and registered busy/done/hi/lo.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_is_div <= 1'b0;
      r_neg_hi <= 1'b0;
      r_neg_lo <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state  <= CALC;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_is_div <= w_is_div;
            if (w_is_div) begin
              r_acc_lo <= w_fa;
              r_b      <= w_fb;
              r_neg_hi <= w_sgn & rs_data[31];
              r_neg_lo <= w_sgn & (rs_data[31] ^ rt_data[31])
                          & (rt_data != 32'd0);
            end else begin
              r_acc_lo <= w_fb;
              r_b      <= w_fa;
              r_neg_hi <= w_sgn & (rs_data[31] ^ rt_data[31]);
              r_neg_lo <= 1'b0;
            end
          end
        end
        CALC: begin
          r_acc_hi <= w_step_hi;
          r_acc_lo <= w_step_lo;
          if (r_cnt == LAST) begin
            r_state <= FIXUP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        FIXUP: begin
          r_state <= DONE;
          r_hi    <= w_fa;
          r_lo    <= w_fb;
          r_done  <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model,
// per-cycle compare, directed corner cases and randomized operations.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int ITER = 32;
  localparam int LAT  = ITER + 2;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_chk = 0;
  int          n_fail = 0;
  bit          chk_en = 1'b0;

  int          m_k = 0;
  logic [63:0] m_res = '0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.ITER(ITER)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  function automatic logic [63:0] ref_op(input logic [1:0] o,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] r;
    logic [31:0] q;
    logic [31:0] m;
    case (o)
      OP_MULTU: r = {32'd0, a} * {32'd0, b};
      OP_MULT:  r = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      OP_DIVU: begin
        if (b == 32'd0) r = {a, 32'hFFFFFFFF};
        else r = {a % b, a / b};
      end
      default: begin
        if (b == 32'd0) begin
          r = {a, 32'hFFFFFFFF};
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          r = {32'd0, 32'h80000000};
        end else begin
          q = $signed(a) / $signed(b);
          m = $signed(a) % $signed(b);
          r = {m, q};
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFFFFFF;
      3: v = 32'h80000000;
      4: v = 32'($urandom_range(0, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference timeline: result known at accept, visible LAT cycles later.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_k  = 0;
      m_hi = '0;
      m_lo = '0;
    end else if (m_k == 0) begin
      if (start && (DIV_EN || !op[1])) begin
        m_k   = 1;
        m_res = ref_op(op, rs_data, rt_data);
      end
    end else begin
      if (m_k == LAT - 1) {m_hi, m_lo} = m_res;
      m_k = (m_k == LAT) ? 0 : m_k + 1;
    end
  end

  // Per-cycle compare against the reference.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ctl", 64'({busy, done}), 64'({m_k != 0, m_k == LAT}));
      chk("hilo", {hi, lo}, {m_hi, m_lo});
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    @(posedge clk);
    #1;
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    @(posedge clk);
    #1;
    start   = 1'b0;
    op      = 2'($urandom);
    rs_data = $urandom;
    rt_data = $urandom;
  endtask

  task automatic wait_done(output int cyc, output int nd, input bit noise,
                           input bit stop, input int span);
    cyc = 0;
    nd  = 0;
    for (int i = 1; i <= span; i++) begin
      @(negedge clk);
      if (done) begin
        if (nd == 0) cyc = i;
        nd++;
        if (stop) break;
      end
      @(posedge clk);
      #1;
      if (noise) begin
        start   = ($urandom_range(0, 3) == 0);
        op      = 2'($urandom);
        rs_data = $urandom;
        rt_data = $urandom;
      end
    end
    start = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit noise);
    int cyc;
    int nd;
    issue(o, a, b);
    wait_done(cyc, nd, noise, 1'b1, 60);
    chk({nm, " lat"}, 64'(cyc), 64'(LAT));
    chk({nm, " res"}, {hi, lo}, ref_op(o, a, b));
  endtask

  initial begin
    int          cyc;
    int          nd;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] saved;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst ctl", 64'({busy, done}), 64'd0);
    chk("rst hilo", {hi, lo}, 64'd0);
    reset  = 1'b1;
    chk_en = 1'b1;

    run_op("multu max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    chk("pin multu", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op("mult -3x7", OP_MULT, 32'hFFFFFFFD, 32'd7, 1'b0);
    chk("pin mult", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    run_op("mult minmin", OP_MULT, 32'h80000000, 32'h80000000, 1'b0);
    chk("pin mult min", {hi, lo}, 64'h40000000_00000000);

    issue(OP_MULTU, 32'd5, 32'd6);
    repeat (9) @(posedge clk);
    #1;
    start   = 1'b1;
    op      = OP_MULTU;
    rs_data = 32'd100;
    rt_data = 32'd100;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, nd, 1'b0, 1'b0, 45);
    chk("busy ignore ndone", 64'(nd), 64'd1);
    chk("busy ignore res", {hi, lo}, 64'd30);

`ifdef MULDIV_DIV_EN
    run_op("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("pin div", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op("divu 100/0", OP_DIVU, 32'd100, 32'd0, 1'b0);
    chk("pin divu0", {hi, lo}, 64'h00000064_FFFFFFFF);
    run_op("div ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("pin div ovf", {hi, lo}, 64'h00000000_80000000);
    run_op("div -9/0", OP_DIV, 32'hFFFFFFF7, 32'd0, 1'b0);
    chk("pin div0", {hi, lo}, 64'hFFFFFFF7_FFFFFFFF);
`else
    saved = {hi, lo};
    issue(OP_DIV, 32'd8, 32'd2);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("nodiv ctl", 64'({busy, done}), 64'd0);
    end
    chk("nodiv hilo", {hi, lo}, saved);
`endif

    issue(DIV_EN ? OP_DIVU : OP_MULTU, 32'd9, 32'd2);
    repeat (13) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort ctl", 64'({busy, done}), 64'd0);
    chk("abort hilo", {hi, lo}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_op("post rst", OP_MULTU, 32'd2, 32'd3, 1'b0);
    chk("pin post rst", {hi, lo}, 64'd6);

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom);
      ra = pick();
      rb = pick();
      if (DIV_EN || !ro[1]) begin
        run_op("rand", ro, ra, rb, 1'b1);
      end else begin
        issue(ro, ra, rb);
        repeat (4) @(negedge clk);
        chk("rand ign", 64'({busy, done}), 64'd0);
      end
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
